// File: rtl/riscmakers_mem_arbiter.sv
// riscmakers_mem_arbiter
//
// Purpose: shares the single memory-adapter request port between the I$ and
// D$ miss/write paths. One requester wins per transaction. D$ has priority,
// and a starvation counter forces an I$ win after StarveLimit consecutive
// I$ losses. A per-tid table records which cache issued each in-flight
// transaction, so that every memory return is routed back to its owner.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   ic_req_i/data_i/tid_i      I$ request (held until ic_ack_o), payload, tid
//   ic_ack_o                   single-cycle accept pulse to I$
//   dc_req_i/data_i/tid_i      D$ request (held until dc_ack_o), payload, tid
//   dc_ack_o                   single-cycle accept pulse to D$
//   mem_req_o/data_o/tid_o     registered request to the adapter
//   mem_ack_i                  adapter accept
//   mem_rtrn_vld_i/tid_i       adapter return
//   ic_rtrn_vld_o/dc_rtrn_vld_o return routed to its owner
//   busy_o                     transactions outstanding or grant in progress
//   err_o                      sticky: a return arrived with an untracked tid
//   perf_*_o                   grant/stall counters (wrap modulo 2**32)
//
// Optional feature: define RISCMAKERS_ARB_PERF_EN to build the perf counters;
// when it is undefined, the perf outputs are tied to 0.

module riscmakers_mem_arbiter #(
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned StarveLimit    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                ic_req_i,
  input  logic [ReqWidth-1:0] ic_data_i,
  input  logic [TidWidth-1:0] ic_tid_i,
  output logic                ic_ack_o,
  input  logic                dc_req_i,
  input  logic [ReqWidth-1:0] dc_data_i,
  input  logic [TidWidth-1:0] dc_tid_i,
  output logic                dc_ack_o,
  output logic                mem_req_o,
  output logic [ReqWidth-1:0] mem_data_o,
  output logic [TidWidth-1:0] mem_tid_o,
  input  logic                mem_ack_i,
  input  logic                mem_rtrn_vld_i,
  input  logic [TidWidth-1:0] mem_rtrn_tid_i,
  output logic                ic_rtrn_vld_o,
  output logic                dc_rtrn_vld_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [31:0]         perf_ic_grants_o,
  output logic [31:0]         perf_dc_grants_o,
  output logic [31:0]         perf_stall_o
);

  localparam int unsigned NumTids  = 2 ** TidWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned StvWidth = $clog2(StarveLimit + 1);

  typedef enum logic [1:0] {StIdle, StGntIc, StGntDc} state_e;

  state_e              r_state;
  logic                r_mem_req;
  logic [ReqWidth-1:0] r_mem_data;
  logic [TidWidth-1:0] r_mem_tid;
  logic [NumTids-1:0]  r_valid;
  logic [NumTids-1:0]  r_owner_dc;
  logic [CntWidth-1:0] r_count;
  logic [StvWidth-1:0] r_starve;
  logic                r_err;

  logic w_room, w_ic_elig, w_dc_elig, w_force_ic, w_pick_ic, w_pick_dc;
  logic w_ic_ack, w_dc_ack, w_ack, w_rtrn_hit, w_rtrn_miss;

  // Eligibility uses the registered valid bit only. A return for the same
  // tid in this cycle therefore unblocks the requester one cycle later.
  assign w_room     = r_count < CntWidth'(MaxOutstanding);
  assign w_ic_elig  = ic_req_i && !r_valid[ic_tid_i] && w_room;
  assign w_dc_elig  = dc_req_i && !r_valid[dc_tid_i] && w_room;
  assign w_force_ic = (r_starve == StvWidth'(StarveLimit)) && w_ic_elig;
  assign w_pick_dc  = (r_state == StIdle) && w_dc_elig && !w_force_ic;
  assign w_pick_ic  = (r_state == StIdle) && w_ic_elig && !w_pick_dc;

  assign w_ic_ack = (r_state == StGntIc) && mem_ack_i;
  assign w_dc_ack = (r_state == StGntDc) && mem_ack_i;
  assign w_ack    = w_ic_ack || w_dc_ack;

  assign w_rtrn_hit  = mem_rtrn_vld_i && r_valid[mem_rtrn_tid_i];
  assign w_rtrn_miss = mem_rtrn_vld_i && !r_valid[mem_rtrn_tid_i];

  // Grant FSM with registered request outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_mem_req  <= 1'b0;
      r_mem_data <= '0;
      r_mem_tid  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pick_dc) begin
            r_state    <= StGntDc;
            r_mem_req  <= 1'b1;
            r_mem_data <= dc_data_i;
            r_mem_tid  <= dc_tid_i;
          end else if (w_pick_ic) begin
            r_state    <= StGntIc;
            r_mem_req  <= 1'b1;
            r_mem_data <= ic_data_i;
            r_mem_tid  <= ic_tid_i;
          end
        end
        StGntIc, StGntDc: begin
          if (mem_ack_i) begin
            r_state   <= StIdle;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: counts D$ wins taken while I$ was waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (w_pick_ic) begin
      r_starve <= '0;
    end else if (w_pick_dc && ic_req_i && (r_starve != StvWidth'(StarveLimit))) begin
      r_starve <= r_starve + StvWidth'(1);
    end
  end

  // Tracking table and outstanding count. The granted tid was ineligible
  // while valid, so it never collides with a same-cycle return.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= '0;
      r_owner_dc <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_rtrn_hit) begin
        r_valid[mem_rtrn_tid_i] <= 1'b0;
      end
      if (w_ack) begin
        r_valid[r_mem_tid]    <= 1'b1;
        r_owner_dc[r_mem_tid] <= w_dc_ack;
      end
      if (w_rtrn_miss) begin
        r_err <= 1'b1;
      end
      case ({w_ack, w_rtrn_hit})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ic_ack_o      = w_ic_ack;
  assign dc_ack_o      = w_dc_ack;
  assign mem_req_o     = r_mem_req;
  assign mem_data_o    = r_mem_data;
  assign mem_tid_o     = r_mem_tid;
  assign ic_rtrn_vld_o = w_rtrn_hit && !r_owner_dc[mem_rtrn_tid_i];
  assign dc_rtrn_vld_o = w_rtrn_hit && r_owner_dc[mem_rtrn_tid_i];
  assign busy_o        = (r_count != '0) || (r_state != StIdle);
  assign err_o         = r_err;

`ifdef RISCMAKERS_ARB_PERF_EN
  logic [31:0] r_perf_ic, r_perf_dc, r_perf_stall;
  logic        w_stall;

  // A stall is an idle cycle with a pending request that nobody can take.
  assign w_stall = (r_state == StIdle) && (ic_req_i || dc_req_i) && !w_ic_elig && !w_dc_elig;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_ic    <= '0;
      r_perf_dc    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pick_ic) r_perf_ic <= r_perf_ic + 32'd1;
      if (w_pick_dc) r_perf_dc <= r_perf_dc + 32'd1;
      if (w_stall)   r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ic_grants_o = r_perf_ic;
  assign perf_dc_grants_o = r_perf_dc;
  assign perf_stall_o     = r_perf_stall;
`else
  assign perf_ic_grants_o = '0;
  assign perf_dc_grants_o = '0;
  assign perf_stall_o     = '0;
`endif

endmodule

// File: tb/tb_riscmakers_mem_arbiter.sv
// Testbench for riscmakers_mem_arbiter. Expected grants are pushed to a
// scoreboard queue when requests are driven and popped on each adapter ack.

module tb_riscmakers_mem_arbiter;

`ifdef RISCMAKERS_ARB_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct packed {
    logic       dc;
    logic [1:0] tid;
  } grant_t;

  logic         clk_i, rst_ni;
  logic         ic_req_i, dc_req_i, ic_ack_o, dc_ack_o;
  logic [127:0] ic_data_i, dc_data_i, mem_data_o;
  logic [1:0]   ic_tid_i, dc_tid_i, mem_tid_o, mem_rtrn_tid_i;
  logic         mem_req_o, mem_ack_i, mem_rtrn_vld_i;
  logic         ic_rtrn_vld_o, dc_rtrn_vld_o, busy_o, err_o;
  logic [31:0]  perf_ic_grants_o, perf_dc_grants_o, perf_stall_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  grant_t      sb_q[$];

  riscmakers_mem_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .ic_req_i         (ic_req_i),
    .ic_data_i        (ic_data_i),
    .ic_tid_i         (ic_tid_i),
    .ic_ack_o         (ic_ack_o),
    .dc_req_i         (dc_req_i),
    .dc_data_i        (dc_data_i),
    .dc_tid_i         (dc_tid_i),
    .dc_ack_o         (dc_ack_o),
    .mem_req_o        (mem_req_o),
    .mem_data_o       (mem_data_o),
    .mem_tid_o        (mem_tid_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rtrn_vld_i   (mem_rtrn_vld_i),
    .mem_rtrn_tid_i   (mem_rtrn_tid_i),
    .ic_rtrn_vld_o    (ic_rtrn_vld_o),
    .dc_rtrn_vld_o    (dc_rtrn_vld_o),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .perf_ic_grants_o (perf_ic_grants_o),
    .perf_dc_grants_o (perf_dc_grants_o),
    .perf_stall_o     (perf_stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    ic_req_i = 1'b0; ic_data_i = '0; ic_tid_i = '0;
    dc_req_i = 1'b0; dc_data_i = '0; dc_tid_i = '0;
    mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0; mem_rtrn_tid_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  task automatic wait_mem_req(input int budget);
    for (int i = 0; i < budget && !mem_req_o; i++) step();
    check("mem_req_seen", mem_req_o, 1'b1);
  endtask

  // Acks the pending request and checks it against the scoreboard head.
  task automatic ack_grant(output grant_t g);
    grant_t e;
    e = '0;
    mem_ack_i = 1'b1;
    #1;
    check("sb_nonempty", sb_q.size() != 0, 1'b1);
    if (sb_q.size() != 0) e = sb_q.pop_front();
    check("ack_ic", ic_ack_o, !e.dc);
    check("ack_dc", dc_ack_o, e.dc);
    check("ack_tid", mem_tid_o, e.tid);
    g = e;
    step();
    mem_ack_i = 1'b0;
  endtask

  initial begin
    grant_t e, g;
    rst_ni = 1'b0;
    clear_inputs();
    #3;
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_acks", {ic_ack_o, dc_ack_o}, 2'b00);
    check("rst_rtrn", {ic_rtrn_vld_o, dc_rtrn_vld_o}, 2'b00);
    check("rst_perf", {perf_ic_grants_o, perf_dc_grants_o, perf_stall_o}, '0);
    check("rst_mem_data", mem_data_o, '0);
    do_reset();

    // Single I$ request, adapter acks after 3 cycles, then return.
    ic_req_i = 1'b1; ic_tid_i = 2'd1; ic_data_i = {4{32'hC0DE_0101}};
    sb_q.push_back('{dc: 1'b0, tid: 2'd1});
    #1;
    check("t1_req_lat0", mem_req_o, 1'b0);
    step();
    check("t1_req_lat1", mem_req_o, 1'b1);
    check("t1_tid", mem_tid_o, 2'd1);
    check("t1_data", mem_data_o, {4{32'hC0DE_0101}});
    check("t1_busy", busy_o, 1'b1);
    step(); step();
    check("t1_req_held", mem_req_o, 1'b1);
    ack_grant(g);
    ic_req_i = 1'b0;
    #1;
    check("t1_req_drop", mem_req_o, 1'b0);
    check("t1_busy_out", busy_o, 1'b1);
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd1;
    #1;
    check("t1_rtrn_ic", ic_rtrn_vld_o, 1'b1);
    check("t1_rtrn_dc", dc_rtrn_vld_o, 1'b0);
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("t1_idle", busy_o, 1'b0);
    check("t1_err", err_o, 1'b0);

    // Both requesting continuously: 8 D$ grants, then 1 I$ grant, repeating.
    do_reset();
    ic_req_i = 1'b1; ic_tid_i = 2'd0; dc_req_i = 1'b1; dc_tid_i = 2'd1;
    for (int k = 0; k < 27; k++) begin
      e.dc  = (k % 9) != 8;
      e.tid = e.dc ? dc_tid_i : 2'd0;
      sb_q.push_back(e);
      wait_mem_req(4);
      ack_grant(g);
      if (k == 26) begin
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
      end
      mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = g.tid;
      if (g.dc) dc_tid_i = (dc_tid_i == 2'd3) ? 2'd1 : dc_tid_i + 2'd1;
      #1;
      check("starve_rtrn_ic", ic_rtrn_vld_o, !g.dc);
      check("starve_rtrn_dc", dc_rtrn_vld_o, g.dc);
      step();
      mem_rtrn_vld_i = 1'b0;
    end
    #1;
    check("starve_done_req", mem_req_o, 1'b0);
    check("starve_done_busy", busy_o, 1'b0);
    check("starve_perf_ic", perf_ic_grants_o, PerfEn ? 32'd3 : 32'd0);
    check("starve_perf_dc", perf_dc_grants_o, PerfEn ? 32'd24 : 32'd0);

    // Fill all 4 slots, then the 5th request stalls until a return.
    do_reset();
    dc_req_i = 1'b1; dc_tid_i = 2'd0;
    for (int j = 0; j < 4; j++) begin
      sb_q.push_back('{dc: 1'b1, tid: 2'(j)});
      wait_mem_req(4);
      ack_grant(g);
      dc_tid_i = 2'((j + 1) % 4);
    end
    #1;
    check("full_req0", mem_req_o, 1'b0);
    check("full_stall0", perf_stall_o, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      #1;
      check("full_blocked", mem_req_o, 1'b0);
      check("full_stall", perf_stall_o, PerfEn ? 32'(i) : 32'd0);
    end
    sb_q.push_back('{dc: 1'b1, tid: 2'd0});
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd0;
    #1;
    check("full_rtrn_dc", dc_rtrn_vld_o, 1'b1);
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("full_free_lat", mem_req_o, 1'b0);
    check("full_stall6", perf_stall_o, PerfEn ? 32'd6 : 32'd0);
    step();
    #1;
    check("full_grant", mem_req_o, 1'b1);
    check("full_perf_dc", perf_dc_grants_o, PerfEn ? 32'd5 : 32'd0);
    ack_grant(g);
    dc_req_i = 1'b0;

    // D$ tid 2 blocked while I$ holds tid 2; grant latched the cycle after return.
    do_reset();
    ic_req_i = 1'b1; ic_tid_i = 2'd2;
    sb_q.push_back('{dc: 1'b0, tid: 2'd2});
    wait_mem_req(4);
    ack_grant(g);
    ic_req_i = 1'b0;
    dc_req_i = 1'b1; dc_tid_i = 2'd2; dc_data_i = {4{32'hDC00_0002}};
    for (int i = 0; i < 3; i++) begin
      #1;
      check("tid_blocked", mem_req_o, 1'b0);
      step();
    end
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd2;
    #1;
    check("tid_rtrn_ic", ic_rtrn_vld_o, 1'b1);
    check("tid_req_n", mem_req_o, 1'b0);
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("tid_req_n1", mem_req_o, 1'b0);
    step();
    #1;
    check("tid_req_n2", mem_req_o, 1'b1);
    check("tid_data", mem_data_o, {4{32'hDC00_0002}});
    sb_q.push_back('{dc: 1'b1, tid: 2'd2});
    ack_grant(g);
    dc_req_i = 1'b0;

    // Untracked return sets a sticky error.
    do_reset();
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd3;
    #1;
    check("err_no_rtrn", {ic_rtrn_vld_o, dc_rtrn_vld_o}, 2'b00);
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("err_set", err_o, 1'b1);
    repeat (3) step();
    check("err_sticky", err_o, 1'b1);
    check("err_busy", busy_o, 1'b0);

    // Reset in GNT_DC with 2 entries outstanding drops everything.
    dc_req_i = 1'b1; dc_tid_i = 2'd0;
    for (int j = 0; j < 2; j++) begin
      sb_q.push_back('{dc: 1'b1, tid: 2'(j)});
      wait_mem_req(4);
      ack_grant(g);
      dc_tid_i = 2'(j + 1);
    end
    wait_mem_req(4);
    mem_ack_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("mrst_req", mem_req_o, 1'b0);
    check("mrst_ack", dc_ack_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_err", err_o, 1'b0);
    clear_inputs();
    repeat (2) step();
    rst_ni = 1'b1;
    step();
    dc_req_i = 1'b1; dc_tid_i = 2'd0;
    sb_q.push_back('{dc: 1'b1, tid: 2'd0});
    wait_mem_req(4);
    ack_grant(g);
    dc_req_i = 1'b0;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 2'd0;
    #1;
    check("mrst_rtrn_dc", dc_rtrn_vld_o, 1'b1);
    step();
    mem_rtrn_vld_i = 1'b0;
    #1;
    check("mrst_idle", busy_o, 1'b0);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscmakers_mem_arbiter.md
Name: riscmakers_mem_arbiter

Overview:
Shares the single memory adapter request port between the I$ and D$ miss/write paths in the cache subsystem. Selects one requester per transaction with D$ priority and I$ starvation protection. Tracks outstanding transaction IDs and routes each memory return to the requester that issued it. Sits between the cache request outputs and the adapter request/return ports.

Parameters:
ReqWidth, 128, width of the flattened request payload (address, size, data, type).
TidWidth, 2, transaction ID width; the tracking table has 2**TidWidth entries.
MaxOutstanding, 4, maximum in-flight transactions (1..2**TidWidth).
StarveLimit, 8, I$ losses in a row before I$ is forced to win (>=1).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ic_req_i  in  1  I$ request; held until ic_ack_o
ic_data_i  in  ReqWidth  I$ payload
ic_tid_i  in  TidWidth  I$ transaction ID
ic_ack_o  out  1  single-cycle accept pulse to I$
dc_req_i  in  1  D$ request; held until dc_ack_o
dc_data_i  in  ReqWidth  D$ payload
dc_tid_i  in  TidWidth  D$ transaction ID
dc_ack_o  out  1  single-cycle accept pulse to D$
mem_req_o  out  1  request to the adapter
mem_data_o  out  ReqWidth  registered payload of the winner
mem_tid_o  out  TidWidth  registered ID of the winner
mem_ack_i  in  1  adapter accept
mem_rtrn_vld_i  in  1  return valid from the adapter
mem_rtrn_tid_i  in  TidWidth  return ID
ic_rtrn_vld_o  out  1  return belongs to I$
dc_rtrn_vld_o  out  1  return belongs to D$
busy_o  out  1  at least one transaction outstanding, or the FSM is not in IDLE
err_o  out  1  sticky: a return arrived with an untracked ID
perf_ic_grants_o  out  32  I$ grant count
perf_dc_grants_o  out  32  D$ grant count
perf_stall_o  out  32  cycles a request was blocked by the table or the limit

Behaviour:
- Reset, asynchronous: FSM to IDLE; table valid bits, outstanding count, starve counter, err and perf counters to 0. All outputs are 0 during and right after reset. The same applies when reset asserts mid-transaction, and the in-flight grant is dropped.
- FSM states: IDLE, GNT_IC, GNT_DC.
- A requester is eligible when its req is high, the table entry for its tid is not valid (registered state), and the outstanding count is below MaxOutstanding.
- Winner selection in IDLE:
  - D$ wins if eligible, unless starve_cnt == StarveLimit and I$ is eligible.
  - Otherwise I$ wins if eligible.
- When there is a winner: latch data and tid into mem_data_o and mem_tid_o, and go to GNT_x. mem_req_o rises the next cycle, so request-to-mem_req latency is 1 cycle.
- GNT_x:
  - mem_req_o = 1 and the payload is stable.
  - On mem_ack_i: the matching x_ack_o pulses combinationally in the same cycle, table[tid] is set {valid, owner = x}, count increments, and the FSM returns to IDLE.
  - If req stays high after the ack, it is a new request and is arbitrated again.
- Starve counter:
  - Increments (saturating at StarveLimit) on every D$ grant while ic_req_i is high.
  - Clears on every I$ grant.
- Return path:
  - If mem_rtrn_vld_i is high and table[mem_rtrn_tid_i] is valid: assert ic_rtrn_vld_o or dc_rtrn_vld_o combinationally according to the owner, clear the entry, and decrement the count.
  - If the entry is not valid: no rtrn_vld output, set err_o; err_o is cleared only by reset.
- Simultaneous ack and return in one cycle: the count is unchanged, and both table updates apply. The return and grant tids always differ because eligibility used the registered valid bit.
- A return whose tid equals the requester's tid in that cycle: the requester stays ineligible that cycle and is eligible the next (conservative by 1 cycle).
- Full: when count == MaxOutstanding, no new grant; IDLE holds, and any pending req increments perf_stall_o.
- Empty: busy_o = 0 exactly when count == 0 and the FSM is in IDLE.
- Perf counters wrap modulo 2**32.

Optional Feature:
RISCMAKERS_ARB_PERF_EN
- Defined: the three perf counters are implemented as described.
- Undefined: the counter registers are not instantiated and the perf outputs are tied to 0. Arbitration is unaffected.

Test Plan:
- Single I$ request, tid 1, adapter acks after 3 cycles -> mem_req_o rises cycle 1 and mem_tid_o = 1; ic_ack_o pulses in the ack cycle. A return with tid 1 then gives ic_rtrn_vld_o = 1 and busy_o falls.
- I$ and D$ requesting continuously, with immediate acks and StarveLimit = 8 -> grant order is 8 D$ grants then 1 I$ grant, repeating; no requester waits more than 9 grants.
- MaxOutstanding = 4 with 4 D$ grants and no returns -> a 5th request is never granted and perf_stall_o increments each cycle. One return frees a slot, and the grant follows 1 cycle later.
- D$ request with tid 2 while tid 2 is outstanding -> it is blocked. The return with tid 2 arrives in cycle N, and the grant is latched in cycle N+1.
- Return with tid 3 while nothing is outstanding -> no rtrn_vld output, err_o = 1 and stays set until reset.
- Reset asserted while in GNT_DC with 2 entries outstanding -> all outputs are 0 immediately. After release, a fresh request using a previously outstanding tid is accepted.
